// File: rtl/banked_mem_arbiter_if.sv
// Requester A/B handshake plus memory-side bus for banked_mem_arbiter.
// The arbiter uses the slave modport; the clients and memory side use master.
interface banked_mem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [10:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [10:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [7:0]  b_rdata;

    logic        mem_ren;
    logic        mem_wen;
    logic [10:0] mem_raddr;
    logic [10:0] mem_waddr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_dout,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_dout,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din
    );
endinterface

// File: rtl/banked_mem_arbiter.sv
// Two-requester arbiter for a banked memory: dual-issues a read and a write on different
// sub-banks, otherwise round-robin with burst limit. Optional stats: BANKED_MEM_ARBITER_STATS_EN.
//
// state   | meaning
// PRIO_A  | requester A wins the next conflict
// PRIO_B  | requester B wins the next conflict
module banked_mem_arbiter #(
    parameter int BURST_MAX = 1,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    banked_mem_arbiter_if.slave   bus
`ifdef BANKED_MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]           conflict_cnt,
    output logic [15:0]           dual_cnt,
    output logic [15:0]           stall_b
`endif
);

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

    // A burst limit of zero would never hand priority over, so it behaves as one.
    localparam int              BM   = (BURST_MAX < 1) ? 1 : BURST_MAX;
    localparam logic [CNT_W-1:0] BM_C = CNT_W'(BM);

    prio_t            r_prio;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rd_a;
    logic             r_rd_b;

    logic             w_a_req;
    logic             w_b_req;
    logic             w_both;
    logic             w_conflict;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_a_rd;
    logic             w_a_wr;
    logic             w_b_rd;
    logic             w_b_wr;
    logic [CNT_W-1:0] w_cnt_inc;

    // Requests are masked by reset so every grant and enable is low while rst_n=0.
    assign w_a_req    = bus.a_req & rst_n;
    assign w_b_req    = bus.b_req & rst_n;
    assign w_both     = w_a_req & w_b_req;
    assign w_conflict = w_both & ((bus.a_we == bus.b_we) |
                                  (bus.a_addr[10:7] == bus.b_addr[10:7]));
    assign w_a_gnt    = w_a_req & (~w_conflict | (r_prio == PRIO_A));
    assign w_b_gnt    = w_b_req & (~w_conflict | (r_prio == PRIO_B));
    assign w_a_rd     = w_a_gnt & ~bus.a_we;
    assign w_a_wr     = w_a_gnt &  bus.a_we;
    assign w_b_rd     = w_b_gnt & ~bus.b_we;
    assign w_b_wr     = w_b_gnt &  bus.b_we;
    assign w_cnt_inc  = r_burst_cnt + CNT_W'(1);

    assign bus.a_gnt     = w_a_gnt;
    assign bus.b_gnt     = w_b_gnt;
    assign bus.mem_ren   = w_a_rd | w_b_rd;
    assign bus.mem_wen   = w_a_wr | w_b_wr;
    assign bus.mem_raddr = w_a_rd ? bus.a_addr  : (w_b_rd ? bus.b_addr  : 11'd0);
    assign bus.mem_waddr = w_a_wr ? bus.a_addr  : (w_b_wr ? bus.b_addr  : 11'd0);
    assign bus.mem_din   = w_a_wr ? bus.a_wdata : (w_b_wr ? bus.b_wdata : 8'd0);

    assign bus.a_rvalid = r_rd_a;
    assign bus.b_rvalid = r_rd_b;
    assign bus.a_rdata  = r_rd_a ? bus.mem_dout : 8'd0;
    assign bus.b_rdata  = r_rd_b ? bus.mem_dout : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio      <= PRIO_A;
            r_burst_cnt <= '0;
            r_rd_a      <= 1'b0;
            r_rd_b      <= 1'b0;
        end else begin
            r_rd_a <= w_a_rd;
            r_rd_b <= w_b_rd;
            if (w_conflict) begin
                if (w_cnt_inc >= BM_C) begin
                    r_prio      <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
                    r_burst_cnt <= '0;
                end else begin
                    r_burst_cnt <= w_cnt_inc;
                end
            end else if (w_a_req && !w_b_req && (r_prio == PRIO_B)) begin
                r_prio      <= PRIO_A;
                r_burst_cnt <= '0;
            end else if (w_b_req && !w_a_req && (r_prio == PRIO_A)) begin
                r_prio      <= PRIO_B;
                r_burst_cnt <= '0;
            end
        end
    end

`ifdef BANKED_MEM_ARBITER_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [15:0] r_dual_cnt;
    logic [15:0] r_stall_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= 16'd0;
            r_dual_cnt     <= 16'd0;
            r_stall_b      <= 16'd0;
        end else begin
            if (w_conflict && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            if (w_both && !w_conflict && (r_dual_cnt != 16'hFFFF))
                r_dual_cnt <= r_dual_cnt + 16'd1;
            if (w_b_req && !w_b_gnt && (r_stall_b != 16'hFFFF))
                r_stall_b <= r_stall_b + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign dual_cnt     = r_dual_cnt;
    assign stall_b      = r_stall_b;
`endif

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Bench for banked_mem_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model of the arbiter.
module tb_banked_mem_arbiter;
    localparam int BURST = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_mem_arbiter_if bus();

`ifdef BANKED_MEM_ARBITER_STATS_EN
    logic [15:0] conflict_cnt, dual_cnt, stall_b;
`endif

    banked_mem_arbiter #(.BURST_MAX(BURST), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BANKED_MEM_ARBITER_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .dual_cnt     (dual_cnt),
        .stall_b      (stall_b)
`endif
    );

    // Memory macro stand-in: registered read, synchronous write.
    logic [7:0] mem_arr [0:2047];
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_dout <= mem_arr[bus.mem_raddr];
        if (bus.mem_wen) mem_arr[bus.mem_waddr] <= bus.mem_din;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the contents should be and who owns priority.
    logic [7:0] ref_mem [0:2047];
    bit         m_prio;      // 0 = A owns priority, 1 = B
    int         m_streak;
    bit         m_rd_a, m_rd_b;
    logic [7:0] m_rx_a, m_rx_b;
    bit         m_ga, m_gb;
    int         m_conf, m_dual, m_stall;

    always @(negedge clk) begin
        bit ar, br, conf, ga, gb, ard, awr, brd, bwr;
        logic [10:0] e_raddr, e_waddr;
        logic [7:0]  e_din;
        if (!rst_n) begin
            chk("rst_ctl", 32'({bus.a_gnt, bus.b_gnt, bus.mem_ren, bus.mem_wen,
                                bus.a_rvalid, bus.b_rvalid}), 32'd0);
            chk("rst_bus", 32'({bus.mem_raddr, bus.mem_waddr, bus.mem_din}), 32'd0);
            chk("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
            m_prio = 1'b0; m_streak = 0; m_rd_a = 1'b0; m_rd_b = 1'b0;
            m_ga = 1'b0; m_gb = 1'b0;
            m_conf = 0; m_dual = 0; m_stall = 0;
        end else begin
            ar   = bus.a_req;
            br   = bus.b_req;
            conf = ar && br && ((bus.a_we == bus.b_we) ||
                                (bus.a_addr[10:7] == bus.b_addr[10:7]));
            ga   = ar && (!conf || !m_prio);
            gb   = br && (!conf ||  m_prio);
            ard  = ga && !bus.a_we;  awr = ga && bus.a_we;
            brd  = gb && !bus.b_we;  bwr = gb && bus.b_we;
            e_raddr = ard ? bus.a_addr : (brd ? bus.b_addr : 11'd0);
            e_waddr = awr ? bus.a_addr : (bwr ? bus.b_addr : 11'd0);
            e_din   = awr ? bus.a_wdata : (bwr ? bus.b_wdata : 8'd0);

            chk("gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'({ga, gb}));
            chk("ren_wen", 32'({bus.mem_ren, bus.mem_wen}), 32'({ard || brd, awr || bwr}));
            chk("mem_raddr", 32'(bus.mem_raddr), 32'(e_raddr));
            chk("mem_waddr", 32'(bus.mem_waddr), 32'(e_waddr));
            chk("mem_din", 32'(bus.mem_din), 32'(e_din));
            chk("rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'({m_rd_a, m_rd_b}));
            chk("a_rdata", 32'(bus.a_rdata), 32'(m_rd_a ? m_rx_a : 8'd0));
            chk("b_rdata", 32'(bus.b_rdata), 32'(m_rd_b ? m_rx_b : 8'd0));
`ifdef BANKED_MEM_ARBITER_STATS_EN
            chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
            chk("dual_cnt", 32'(dual_cnt), 32'(m_dual));
            chk("stall_b", 32'(stall_b), 32'(m_stall));
`endif
            m_rd_a = ard;
            m_rd_b = brd;
            if (ard) m_rx_a = ref_mem[bus.a_addr];
            if (brd) m_rx_b = ref_mem[bus.b_addr];
            if (awr) ref_mem[bus.a_addr] = bus.a_wdata;
            if (bwr) ref_mem[bus.b_addr] = bus.b_wdata;

            if (conf) begin
                m_streak++;
                if (m_streak >= ((BURST < 1) ? 1 : BURST)) begin
                    m_prio   = !m_prio;
                    m_streak = 0;
                end
            end else if (ar != br) begin
                if (m_prio != br) begin
                    m_prio   = br;
                    m_streak = 0;
                end
            end
            if (conf && m_conf < 65535) m_conf++;
            if (ar && br && !conf && m_dual < 65535) m_dual++;
            if (br && !gb && m_stall < 65535) m_stall++;
            m_ga = ga;
            m_gb = gb;
        end
    end

    task automatic set_a(input bit req, input bit we, input logic [10:0] addr, input logic [7:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [10:0] addr, input logic [7:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    task automatic to_drive;
        @(posedge clk); #1;
    endtask

    task automatic to_mid;
        @(negedge clk); #1;
    endtask

    function automatic logic [10:0] rand_addr();
        logic [3:0] bank;
        logic [3:0] low;
        bank = 4'($urandom_range(0, 3));
        low  = 4'($urandom_range(0, 15));
        return {bank, 3'b000, low};
    endfunction

    logic [1:0] pat [0:6];
    bit a_act, b_act;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem_arr[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        pat[0] = 2'b10; pat[1] = 2'b10; pat[2] = 2'b10;
        pat[3] = 2'b01; pat[4] = 2'b01; pat[5] = 2'b01; pat[6] = 2'b10;
        set_a(1'b1, 1'b0, 11'h005, 8'h00);
        set_b(1'b0, 1'b0, 11'h000, 8'h00);

        // Requests present during reset must not be granted.
        to_mid;
        chk("rst_force_lit", 32'({bus.a_gnt, bus.b_gnt, bus.mem_ren, bus.mem_wen}), 32'd0);
        to_drive;
        rst_n = 1'b1;

        // Single write then read-back.
        set_a(1'b1, 1'b1, 11'h005, 8'h3C);
        to_mid;
        chk("w1_gnt", 32'(bus.a_gnt), 32'd1);
        chk("w1_mem", 32'({bus.mem_wen, bus.mem_waddr, bus.mem_din}), 32'({1'b1, 11'h005, 8'h3C}));
        to_drive;
        set_a(1'b1, 1'b0, 11'h005, 8'h00);
        to_mid;
        chk("r1_gnt", 32'({bus.a_gnt, bus.mem_ren, bus.mem_raddr}), 32'({2'b11, 11'h005}));
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        chk("r1_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(2'b10));
        chk("r1_rdata", 32'(bus.a_rdata), 32'h3C);

        // Dual issue: write bank 1 while reading bank 0.
        to_drive;
        set_a(1'b1, 1'b1, 11'h080, 8'h5A);
        set_b(1'b1, 1'b0, 11'h005, 8'h00);
        to_mid;
        chk("dual_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'(2'b11));
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        set_b(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        chk("dual_b_rdata", 32'({bus.b_rvalid, bus.b_rdata}), 32'({1'b1, 8'h3C}));
        to_drive;
        set_a(1'b1, 1'b0, 11'h080, 8'h00);
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        chk("dual_readback", 32'(bus.a_rdata), 32'h5A);

        // Same sub-bank read/write conflict: A first, B next cycle.
        to_drive;
        set_a(1'b1, 1'b0, 11'h010, 8'h00);
        set_b(1'b1, 1'b1, 11'h011, 8'h77);
        to_mid;
        chk("conf_c1", 32'({bus.a_gnt, bus.b_gnt}), 32'(2'b10));
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        chk("conf_c2", 32'({bus.a_gnt, bus.b_gnt}), 32'(2'b01));
        to_drive;
        set_b(1'b0, 1'b0, 11'h000, 8'h00);
        set_a(1'b1, 1'b0, 11'h011, 8'h00);
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        chk("conf_readback", 32'(bus.a_rdata), 32'h77);
`ifdef BANKED_MEM_ARBITER_STATS_EN
        chk("stats_lit", 32'({conflict_cnt[7:0], dual_cnt[7:0], stall_b[7:0]}), 32'h010101);
`endif

        // Async reset right after a read grant.
        to_drive;
        set_a(1'b1, 1'b0, 11'h005, 8'h00);
        to_drive;
        chk("arst_pre", 32'({bus.a_rvalid, bus.a_gnt}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1 chk("arst_now", 32'({bus.a_gnt, bus.b_gnt, bus.mem_ren, bus.mem_wen,
                                 bus.a_rvalid, bus.b_rvalid}), 32'd0);
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        to_drive;
        rst_n = 1'b1;
        to_mid;
        chk("arst_stale1", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
        to_mid;
        chk("arst_stale2", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);

        // Burst limit 3 with both reading continuously; also shows prio=A after reset.
        to_drive;
        set_a(1'b1, 1'b0, 11'h005, 8'h00);
        set_b(1'b1, 1'b0, 11'h080, 8'h00);
        for (int i = 0; i < 7; i++) begin
            to_mid;
            chk("burst_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'(pat[i]));
            if (i > 0) begin
                chk("burst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'(pat[i-1]));
                chk("burst_rdata", 32'({bus.a_rdata, bus.b_rdata}),
                    (pat[i-1] == 2'b10) ? 32'h3C00 : 32'h005A);
            end
            to_drive;
        end
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        set_b(1'b0, 1'b0, 11'h000, 8'h00);

        // Random traffic; each requester holds its request until granted.
        a_act = 1'b0;
        b_act = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            to_drive;
            if (!a_act || m_ga) begin
                a_act = ($urandom_range(0, 3) != 0);
                set_a(a_act, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
            if (!b_act || m_gb) begin
                b_act = ($urandom_range(0, 3) != 0);
                set_b(b_act, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
        end
        to_drive;
        set_a(1'b0, 1'b0, 11'h000, 8'h00);
        set_b(1'b0, 1'b0, 11'h000, 8'h00);
        to_mid;
        to_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
